// File: rtl/axi_mem_pkg.sv
// Shared widths, AXI response codes, burst and FSM encodings, plus the
// per-beat address step helper for the dual-master RAM subsystem.
package axi_mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } fsm_state_e;

  // WRAP and reserved bursts step like INCR; sizes above one word clamp to a word.
  function automatic logic [2:0] beat_bytes(input logic [2:0] size, input logic [1:0] burst);
    if (burst == BURST_FIXED) return 3'd0;
    else if (size >= 3'd2)    return 3'd4;
    else                      return 3'd1 << size;
  endfunction
endpackage

// File: rtl/axi_dual_master_bram_if.sv
// One AXI4 port (AW/W/B/AR/R) as seen between an external master and the RAM.
interface axi_dual_master_bram_if;
  import axi_mem_pkg::*;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid,
           bready, arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid,
           bready, arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/bram_sp.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read
// (read-before-write); the output only changes on enabled cycles.
module bram_sp
  import axi_mem_pkg::*;
#(
  parameter int WORDS = 2048,
  parameter int AW    = 11
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/axi_dual_master_bram.sv
// Two AXI4 slave ports sharing one byte-writable RAM, one transaction at a time,
// round-robin between ports. Define AXI_STALL_GUARD_EN to abort stalled masters.
module axi_dual_master_bram
  import axi_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h4000_0000,
  parameter int                MEM_BYTES     = 8192,
  parameter int                STALL_TIMEOUT = 1024
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_rtl_0,
  axi_dual_master_bram_if.slave   s0,
  axi_dual_master_bram_if.slave   s1,
  output logic [1:0]              stall_abort
);
  localparam int OFF_W = $clog2(MEM_BYTES);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] WDATA = ST_WDATA;
  localparam logic [1:0] WRESP = ST_WRESP;
  localparam logic [1:0] RDATA = ST_RDATA;

  logic [1:0] awvalid, arvalid, wvalid, wlast, bready, rready;
  logic [1:0][ID_W-1:0]   awid, arid;
  logic [1:0][ADDR_W-1:0] awaddr, araddr;
  logic [1:0][LEN_W-1:0]  awlen, arlen;
  logic [1:0][2:0]        awsize, arsize;
  logic [1:0][1:0]        awburst, arburst;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][3:0]        wstrb;

  assign awvalid = {s1.awvalid, s0.awvalid};
  assign arvalid = {s1.arvalid, s0.arvalid};
  assign wvalid  = {s1.wvalid,  s0.wvalid};
  assign wlast   = {s1.wlast,   s0.wlast};
  assign bready  = {s1.bready,  s0.bready};
  assign rready  = {s1.rready,  s0.rready};
  assign awid    = {s1.awid,    s0.awid};
  assign arid    = {s1.arid,    s0.arid};
  assign awaddr  = {s1.awaddr,  s0.awaddr};
  assign araddr  = {s1.araddr,  s0.araddr};
  assign awlen   = {s1.awlen,   s0.awlen};
  assign arlen   = {s1.arlen,   s0.arlen};
  assign awsize  = {s1.awsize,  s0.awsize};
  assign arsize  = {s1.arsize,  s0.arsize};
  assign awburst = {s1.awburst, s0.awburst};
  assign arburst = {s1.arburst, s0.arburst};
  assign wdata   = {s1.wdata,   s0.wdata};
  assign wstrb   = {s1.wstrb,   s0.wstrb};

  logic [1:0]        state_reg;
  logic              run_reg, ptr_reg, gnt_reg;
  logic              decerr_reg, slverr_reg, rvalid_reg;
  logic [ID_W-1:0]   id_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [LEN_W-1:0]  len_reg, cnt_reg;
  logic [2:0]        step_reg;
  logic              abort;

  // run_reg keeps address-channel readies low while reset is held.
  logic [1:0]        req;
  logic              gnt_idx, take, take_wr, take_rd;
  logic [ADDR_W-1:0] a_rel;
  logic [ID_W-1:0]   a_id;
  logic [LEN_W-1:0]  a_len;
  logic [2:0]        a_step;
  logic              in_win;

  assign req     = awvalid | arvalid;
  assign gnt_idx = (req[0] && (!ptr_reg || !req[1])) ? 1'b0 : 1'b1;
  assign take    = run_reg && (state_reg == IDLE) && (req != 2'b00);
  assign take_wr = take && awvalid[gnt_idx];
  assign take_rd = take && !awvalid[gnt_idx];
  assign a_rel   = (take_wr ? awaddr[gnt_idx] : araddr[gnt_idx]) - BASE_ADDR;
  assign a_id    = take_wr ? awid[gnt_idx] : arid[gnt_idx];
  assign a_len   = take_wr ? awlen[gnt_idx] : arlen[gnt_idx];
  assign a_step  = take_wr ? beat_bytes(awsize[gnt_idx], awburst[gnt_idx])
                           : beat_bytes(arsize[gnt_idx], arburst[gnt_idx]);
  assign in_win  = a_rel < ADDR_W'(MEM_BYTES);

  logic wbeat, rbeat, last;
  assign last  = cnt_reg == len_reg;
  assign wbeat = (state_reg == WDATA) && wvalid[gnt_reg];
  assign rbeat = (state_reg == RDATA) && rvalid_reg && rready[gnt_reg];

  // Reads prefetch: off_reg always holds the address of the beat after the one on R.
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [OFF_W-3:0]  ram_addr;
  logic [DATA_W-1:0] ram_q;
  assign ram_en   = take_rd || (wbeat && !decerr_reg) || (rbeat && !last);
  assign ram_we   = (wbeat && !decerr_reg) ? wstrb[gnt_reg] : 4'b0000;
  assign ram_addr = take_rd ? a_rel[OFF_W-1:2] : off_reg[OFF_W-1:2];

  bram_sp #(.WORDS(MEM_BYTES / 4), .AW(OFF_W - 2)) u_ram (
    .clk   (clk_100MHz),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata[gnt_reg]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state_reg  <= IDLE;
      run_reg    <= 1'b0;
      ptr_reg    <= 1'b0;
      gnt_reg    <= 1'b0;
      decerr_reg <= 1'b0;
      slverr_reg <= 1'b0;
      rvalid_reg <= 1'b0;
      id_reg     <= '0;
      off_reg    <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
      step_reg   <= '0;
    end else begin
      run_reg <= 1'b1;
      if (abort) begin
        state_reg  <= IDLE;
        rvalid_reg <= 1'b0;
        ptr_reg    <= ~gnt_reg;
      end else begin
        case (state_reg)
          IDLE: if (take) begin
            gnt_reg    <= gnt_idx;
            ptr_reg    <= ~gnt_idx;
            id_reg     <= a_id;
            len_reg    <= a_len;
            step_reg   <= a_step;
            decerr_reg <= !in_win;
            slverr_reg <= 1'b0;
            cnt_reg    <= '0;
            if (take_wr) begin
              off_reg   <= a_rel[OFF_W-1:0];
              state_reg <= WDATA;
            end else begin
              off_reg    <= a_rel[OFF_W-1:0] + OFF_W'(a_step);
              rvalid_reg <= 1'b1;
              state_reg  <= RDATA;
            end
          end
          WDATA: if (wbeat) begin
            off_reg <= off_reg + OFF_W'(step_reg);
            cnt_reg <= cnt_reg + LEN_W'(1);
            if (wlast[gnt_reg] != last) slverr_reg <= 1'b1;
            if (last) state_reg <= WRESP;
          end
          WRESP: if (bready[gnt_reg]) state_reg <= IDLE;
          RDATA: if (rbeat) begin
            off_reg <= off_reg + OFF_W'(step_reg);
            cnt_reg <= cnt_reg + LEN_W'(1);
            if (last) begin
              rvalid_reg <= 1'b0;
              state_reg  <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

`ifdef AXI_STALL_GUARD_EN
  localparam int SC_W = $clog2(STALL_TIMEOUT + 1);
  logic [SC_W-1:0] stall_cnt_reg;
  logic [1:0]      stall_abort_reg;
  logic            stalled;

  assign stalled = ((state_reg == WRESP) && !bready[gnt_reg]) ||
                   ((state_reg == RDATA) && rvalid_reg && !rready[gnt_reg]) ||
                   ((state_reg == WDATA) && !wvalid[gnt_reg]);
  assign abort       = stalled && (stall_cnt_reg == SC_W'(STALL_TIMEOUT - 1));
  assign stall_abort = stall_abort_reg;

  always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      stall_cnt_reg   <= '0;
      stall_abort_reg <= 2'b00;
    end else begin
      if (take) stall_cnt_reg <= '0;
      else if (stalled) stall_cnt_reg <= stall_cnt_reg + SC_W'(1);
      if (abort) stall_abort_reg[gnt_reg] <= 1'b1;
    end
  end
`else
  assign abort       = 1'b0;
  assign stall_abort = 2'b00;
`endif

  logic [1:0] resp_w;
  assign resp_w = decerr_reg ? RESP_DECERR : (slverr_reg ? RESP_SLVERR : RESP_OKAY);

  assign s0.awready = take_wr && !gnt_idx;
  assign s1.awready = take_wr && gnt_idx;
  assign s0.arready = take_rd && !gnt_idx;
  assign s1.arready = take_rd && gnt_idx;
  assign s0.wready  = (state_reg == WDATA) && !gnt_reg;
  assign s1.wready  = (state_reg == WDATA) && gnt_reg;
  assign s0.bvalid  = (state_reg == WRESP) && !gnt_reg;
  assign s1.bvalid  = (state_reg == WRESP) && gnt_reg;
  assign s0.rvalid  = rvalid_reg && !gnt_reg;
  assign s1.rvalid  = rvalid_reg && gnt_reg;
  assign s0.bid     = id_reg;
  assign s1.bid     = id_reg;
  assign s0.bresp   = resp_w;
  assign s1.bresp   = resp_w;
  assign s0.rid     = id_reg;
  assign s1.rid     = id_reg;
  assign s0.rresp   = decerr_reg ? RESP_DECERR : RESP_OKAY;
  assign s1.rresp   = decerr_reg ? RESP_DECERR : RESP_OKAY;
  assign s0.rdata   = decerr_reg ? '0 : ram_q;
  assign s1.rdata   = decerr_reg ? '0 : ram_q;
  assign s0.rlast   = rvalid_reg && last;
  assign s1.rlast   = rvalid_reg && last;
endmodule

// File: tb/tb_axi_dual_master_bram.sv
// Directed bench for axi_dual_master_bram: single/burst writes and reads, wlast
// errors, decode errors, address wrap, starvation under a stalled s1, fairness.
module tb_axi_dual_master_bram;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_dual_master_bram_if bus[2] ();
  logic [1:0] stall_abort;

  axi_dual_master_bram dut (
    .clk_100MHz  (clk),
    .reset_rtl_0 (rst_n),
    .s0          (bus[0]),
    .s1          (bus[1]),
    .stall_abort (stall_abort)
  );

  logic [3:0]  awid_d[2], arid_d[2], wstrb_d[2];
  logic [31:0] awaddr_d[2], araddr_d[2], wdata_d[2];
  logic [7:0]  awlen_d[2], arlen_d[2];
  logic [2:0]  awsize_d[2], arsize_d[2];
  logic [1:0]  awburst_d[2], arburst_d[2];
  logic        awvalid_d[2], arvalid_d[2], wvalid_d[2], wlast_d[2], bready_d[2], rready_d[2];
  logic        awready_o[2], wready_o[2], bvalid_o[2], arready_o[2], rvalid_o[2], rlast_o[2];
  logic [3:0]  bid_o[2], rid_o[2];
  logic [1:0]  bresp_o[2], rresp_o[2];
  logic [31:0] rdata_o[2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_m
      assign bus[gi].awid    = awid_d[gi];
      assign bus[gi].awaddr  = awaddr_d[gi];
      assign bus[gi].awlen   = awlen_d[gi];
      assign bus[gi].awsize  = awsize_d[gi];
      assign bus[gi].awburst = awburst_d[gi];
      assign bus[gi].awvalid = awvalid_d[gi];
      assign bus[gi].wdata   = wdata_d[gi];
      assign bus[gi].wstrb   = wstrb_d[gi];
      assign bus[gi].wlast   = wlast_d[gi];
      assign bus[gi].wvalid  = wvalid_d[gi];
      assign bus[gi].bready  = bready_d[gi];
      assign bus[gi].arid    = arid_d[gi];
      assign bus[gi].araddr  = araddr_d[gi];
      assign bus[gi].arlen   = arlen_d[gi];
      assign bus[gi].arsize  = arsize_d[gi];
      assign bus[gi].arburst = arburst_d[gi];
      assign bus[gi].arvalid = arvalid_d[gi];
      assign bus[gi].rready  = rready_d[gi];
      assign awready_o[gi]   = bus[gi].awready;
      assign wready_o[gi]    = bus[gi].wready;
      assign bvalid_o[gi]    = bus[gi].bvalid;
      assign bid_o[gi]       = bus[gi].bid;
      assign bresp_o[gi]     = bus[gi].bresp;
      assign arready_o[gi]   = bus[gi].arready;
      assign rvalid_o[gi]    = bus[gi].rvalid;
      assign rid_o[gi]       = bus[gi].rid;
      assign rdata_o[gi]     = bus[gi].rdata;
      assign rresp_o[gi]     = bus[gi].rresp;
      assign rlast_o[gi]     = bus[gi].rlast;
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  int grant_q[$];
  logic [31:0] rd_data[256];
  logic [1:0]  rd_resp[256];
  logic        rd_last[256];
  logic [3:0]  rd_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives AW, len+1 W beats and collects B; starts and ends on a falling edge.
  task automatic axi_write(input int m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [31:0] dbase, input bit good_last,
                           output logic [1:0] resp, output logic [3:0] bid,
                           output logic wr_after, output int wait_cyc);
    int n;
    awid_d[m] = id; awaddr_d[m] = addr; awlen_d[m] = len;
    awsize_d[m] = 3'd2; awburst_d[m] = 2'b01; awvalid_d[m] = 1'b1;
    n = 0;
    #1;
    while (!awready_o[m] && n < LIMIT) begin @(negedge clk); #1; n++; end
    wait_cyc = n;
    chk("aw_grant", {31'd0, awready_o[m]}, 32'd1);
    grant_q.push_back(m);
    @(negedge clk);
    awvalid_d[m] = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata_d[m] = dbase + 32'(i); wstrb_d[m] = 4'hF;
      wlast_d[m] = good_last && (i == int'(len)); wvalid_d[m] = 1'b1;
      n = 0;
      #1;
      while (!wready_o[m] && n < LIMIT) begin @(negedge clk); #1; n++; end
      @(negedge clk);
    end
    wvalid_d[m] = 1'b0; wlast_d[m] = 1'b0;
    #1;
    wr_after = wready_o[m];
    bready_d[m] = 1'b1;
    n = 0;
    while (!bvalid_o[m] && n < LIMIT) begin @(negedge clk); #1; n++; end
    chk("b_seen", {31'd0, bvalid_o[m]}, 32'd1);
    resp = bresp_o[m]; bid = bid_o[m];
    @(negedge clk);
    bready_d[m] = 1'b0;
  endtask

  task automatic axi_read(input int m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, output logic first_valid);
    int n;
    arid_d[m] = id; araddr_d[m] = addr; arlen_d[m] = len;
    arsize_d[m] = 3'd2; arburst_d[m] = 2'b01; arvalid_d[m] = 1'b1; rready_d[m] = 1'b1;
    n = 0;
    #1;
    while (!arready_o[m] && n < LIMIT) begin @(negedge clk); #1; n++; end
    chk("ar_grant", {31'd0, arready_o[m]}, 32'd1);
    @(negedge clk);
    arvalid_d[m] = 1'b0;
    #1;
    first_valid = rvalid_o[m];
    rd_id = rid_o[m];
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!rvalid_o[m] && n < LIMIT) begin @(negedge clk); #1; n++; end
      rd_data[i] = rdata_o[m]; rd_resp[i] = rresp_o[m]; rd_last[i] = rlast_o[m];
      @(negedge clk);
      #1;
    end
    rready_d[m] = 1'b0;
    @(negedge clk);
  endtask

  logic [1:0] r0, r1;
  logic [3:0] b0, b1;
  logic       wa0, wa1, fv;
  int         w0, w1, max_wait0, seen;

  initial begin
    for (int m = 0; m < 2; m++) begin
      awid_d[m] = '0; awaddr_d[m] = '0; awlen_d[m] = '0; awsize_d[m] = '0; awburst_d[m] = '0;
      awvalid_d[m] = 1'b0; wdata_d[m] = '0; wstrb_d[m] = '0; wlast_d[m] = 1'b0; wvalid_d[m] = 1'b0;
      bready_d[m] = 1'b0; arid_d[m] = '0; araddr_d[m] = '0; arlen_d[m] = '0; arsize_d[m] = '0;
      arburst_d[m] = '0; arvalid_d[m] = 1'b0; rready_d[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_valids", {22'd0, awready_o[1], awready_o[0], arready_o[1], arready_o[0], wready_o[1],
        wready_o[0], bvalid_o[1], bvalid_o[0], rvalid_o[1], rvalid_o[0]}, 32'd0);
    chk("rst_resp", {26'd0, bresp_o[0], rresp_o[0], stall_abort}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write then read back.
    axi_write(0, 4'h3, 32'h4000_0004, 8'd0, 32'hCAFE_0001, 1'b1, r0, b0, wa0, w0);
    chk("single_bresp", {30'd0, r0}, 32'd0);
    chk("single_bid", {28'd0, b0}, 32'h3);
    axi_read(0, 4'h6, 32'h4000_0004, 8'd0, fv);
    chk("single_rdata", rd_data[0], 32'hCAFE_0001);
    chk("single_rlast", {31'd0, rd_last[0]}, 32'd1);
    chk("single_rresp", {30'd0, rd_resp[0]}, 32'd0);
    chk("single_rid", {28'd0, rd_id}, 32'h6);
    chk("rvalid_latency", {31'd0, fv}, 32'd1);

    // INCR burst of four.
    axi_write(0, 4'h1, 32'h4000_0010, 8'd3, 32'h1000_00A0, 1'b1, r0, b0, wa0, w0);
    chk("incr_bresp", {30'd0, r0}, 32'd0);
    axi_read(0, 4'h2, 32'h4000_0010, 8'd3, fv);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_data%0d", i), rd_data[i], 32'h1000_00A0 + 32'(i));
      chk($sformatf("incr_last%0d", i), {31'd0, rd_last[i]}, {31'd0, i == 3});
    end

    // 256-beat s1 burst without wlast, s0 write queued behind it.
    grant_q.delete();
    fork
      axi_write(1, 4'h9, 32'h4000_1000, 8'd255, 32'h5500_0000, 1'b0, r1, b1, wa1, w1);
      begin
        repeat (4) @(negedge clk);
        axi_write(0, 4'h4, 32'h4000_0020, 8'd0, 32'h1234_5678, 1'b1, r0, b0, wa0, w0);
      end
    join
    chk("long_wready_after", {31'd0, wa1}, 32'd0);
    chk("long_bresp", {30'd0, r1}, 32'h2);
    chk("long_bid", {28'd0, b1}, 32'h9);
    chk("queued_s0_bresp", {30'd0, r0}, 32'd0);
    chk("queued_s0_wait_ok", {31'd0, w0 <= 260}, 32'd1);
    chk("long_order_len", grant_q.size(), 32'd2);
    chk("long_order0", grant_q[0], 32'd1);
    axi_read(0, 4'h5, 32'h4000_13F8, 8'd1, fv);
    chk("long_word254", rd_data[0], 32'h5500_00FE);
    chk("long_word255", rd_data[1], 32'h5500_00FF);
    axi_read(1, 4'h7, 32'h4000_0020, 8'd0, fv);
    chk("queued_s0_data", rd_data[0], 32'h1234_5678);

    // Address wraps modulo the window; out-of-window write leaves RAM untouched.
    axi_write(0, 4'h0, 32'h4000_1FFC, 8'd1, 32'h7000_0000, 1'b1, r0, b0, wa0, w0);
    axi_read(0, 4'h0, 32'h4000_1FFC, 8'd1, fv);
    chk("wrap_top", rd_data[0], 32'h7000_0000);
    chk("wrap_bottom", rd_data[1], 32'h7000_0001);
    axi_write(0, 4'hB, 32'h5000_0000, 8'd0, 32'hDEAD_BEEF, 1'b1, r0, b0, wa0, w0);
    chk("decerr_bresp", {30'd0, r0}, 32'h3);
    axi_read(0, 4'h0, 32'h4000_0000, 8'd0, fv);
    chk("decerr_ram_kept", rd_data[0], 32'h7000_0001);
    axi_read(1, 4'h0, 32'h5000_0000, 8'd0, fv);
    chk("decerr_rdata", rd_data[0], 32'd0);
    chk("decerr_rresp", {30'd0, rd_resp[0]}, 32'h3);

    // s1 opens a 256-beat read and never takes data.
    arid_d[1] = 4'hE; araddr_d[1] = 32'h4000_0000; arlen_d[1] = 8'd255;
    arsize_d[1] = 3'd2; arburst_d[1] = 2'b01; arvalid_d[1] = 1'b1; rready_d[1] = 1'b0;
    seen = 0;
    #1;
    while (!arready_o[1] && seen < LIMIT) begin @(negedge clk); #1; seen++; end
    chk("stall_ar_grant", {31'd0, arready_o[1]}, 32'd1);
    @(negedge clk);
    arvalid_d[1] = 1'b0;
    #1;
    chk("stall_rvalid", {31'd0, rvalid_o[1]}, 32'd1);
    @(negedge clk);
`ifdef AXI_STALL_GUARD_EN
    axi_write(0, 4'h8, 32'h4000_0040, 8'd0, 32'hABCD_0000, 1'b1, r0, b0, wa0, w0);
    chk("guard_s0_bresp", {30'd0, r0}, 32'd0);
    chk("guard_abort", {30'd0, stall_abort}, 32'h2);
    chk("guard_s1_rvalid", {31'd0, rvalid_o[1]}, 32'd0);
`else
    awid_d[0] = 4'h8; awaddr_d[0] = 32'h4000_0040; awlen_d[0] = 8'd0;
    awsize_d[0] = 3'd2; awburst_d[0] = 2'b01; awvalid_d[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      #1;
      if (awready_o[0]) seen++;
      @(negedge clk);
    end
    chk("starved_s0_awready", seen, 32'd0);
    chk("noguard_abort", {30'd0, stall_abort}, 32'd0);
`endif

    // Reset in the middle of the stalled read drops everything immediately.
    rst_n = 1'b0;
    #1;
    chk("midrst_valids", {28'd0, rvalid_o[1], awready_o[0], bvalid_o[0], wready_o[0]}, 32'd0);
    chk("midrst_abort", {30'd0, stall_abort}, 32'd0);
    repeat (2) @(negedge clk);
    awvalid_d[0] = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("postrst_quiet", {30'd0, rvalid_o[1], bvalid_o[1]}, 32'd0);

    // Both masters request back to back: grants alternate starting at s0.
    grant_q.delete();
    max_wait0 = 0;
    fork
      for (int k = 0; k < 3; k++) begin
        axi_write(0, 4'h1, 32'h4000_0100 + 32'(4 * k), 8'd0, 32'hA0 + 32'(k), 1'b1, r0, b0, wa0, w0);
        if (w0 > max_wait0) max_wait0 = w0;
      end
      for (int k = 0; k < 3; k++)
        axi_write(1, 4'h2, 32'h4000_0200 + 32'(4 * k), 8'd0, 32'hB0 + 32'(k), 1'b1, r1, b1, wa1, w1);
    join
    chk("rr_count", grant_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), grant_q[i], 32'(i % 2));
    chk("rr_s0_wait_ok", {31'd0, max_wait0 <= 260}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_dual_master_bram.md
Name: axi_dual_master_bram

Overview:
- Two-master AXI4 memory subsystem: two AXI4 slave ports (s0, s1) share one on-chip byte-writable RAM through a round-robin transaction arbiter.
- s0 is the trusted/legitimate master; s1 may be untrusted.
- Sits at the top of the memory test system on the 100 MHz domain, mapped at BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h4000_0000, start of the decoded RAM window.
- MEM_BYTES, 8192, RAM size in bytes (power of 2, ≥4).
- STALL_TIMEOUT, 1024, cycles a granted master may stall B/R before abort (used only with the optional feature).

Ports:
- clk_100MHz  in  1  system clock; all logic on rising edge.
- reset_rtl_0  in  1  asynchronous active-low reset.
- sN_aw{id,addr,len,size,burst,valid}  in  4/32/8/3/2/1  write address channel, N=0,1.
- sN_awready  out  1  write address channel ready.
- sN_w{data,strb,last,valid}  in  32/4/1/1  write data channel.
- sN_wready  out  1  write data channel ready.
- sN_b{id,resp,valid}  out  4/2/1  write response channel.
- sN_bready  in  1  write response ready.
- sN_ar{id,addr,len,size,burst,valid}  in  4/32/8/3/2/1  read address channel.
- sN_arready  out  1  read address channel ready.
- sN_r{id,data,resp,last,valid}  out  4/32/2/1/1  read data channel.
- sN_rready  in  1  read data ready.
- stall_abort  out  2  sticky per-master abort flags; constant 0 without the optional feature.

Behaviour:
- Reset: all ready/valid outputs 0; bresp/rresp 0; stall_abort 0; arbiter pointer to s0; FSM in IDLE. RAM contents are not reset.
- Reset asserted mid-burst abandons the burst at once; no B or R response is produced for it.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- Arbitration happens only in IDLE, one transaction at a time.
  - Requests: sN_awvalid or sN_arvalid.
  - Masters alternate round-robin; the pointer moves past the granted master.
  - Within a master, write wins over read.
- Write grant: awready pulses 1 cycle; ID, address, length, size and burst are latched; go to WDATA.
- WDATA:
  - wready=1 for the granted master only.
  - Each wvalid&wready beat writes wstrb-enabled bytes at word addr[log2(MEM_BYTES)-1:2].
  - Exactly awlen+1 beats are accepted, independent of wlast; then wready drops and the FSM goes to WRESP.
- WRESP: bvalid=1 with bid=latched ID; hold until bready, then IDLE. bresp:
  - DECERR (2'b11) if the start address is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES); no RAM writes are done in that case.
  - Else SLVERR (2'b10) if wlast was 0 on the final beat or 1 on an earlier beat.
  - Else OKAY.
- Read grant: arready pulses 1 cycle; go to RDATA.
  - First rvalid 1 cycle after AR acceptance (synchronous RAM read).
  - One beat per cycle while rready=1; rdata is held stable while stalled.
  - rlast on beat arlen+1; then IDLE.
  - Out-of-window reads return rdata=0 with DECERR on every beat.
- Address stepping:
  - FIXED (00): address constant.
  - INCR (01): address += 1<<size each beat.
  - WRAP (10): treated as INCR.
  - Reserved (11): treated as INCR.
  - size>2: treated as size 2.
  - Address wraps modulo MEM_BYTES inside the window.
- Ungranted master sees all ready/valid outputs at 0.
- Fairness: a pending s0 transaction is granted within one s1 transaction plus 2 cycles.
- Worst case, an s1 burst of length 256 delays s0 by ≤ 260 cycles, provided s1 honours bready/rready.

Optional Feature:
- Macro: AXI_STALL_GUARD_EN.
- Defined:
  - A counter counts cycles where the granted master has bvalid&!bready or rvalid&!rready, or wready&!wvalid.
  - At STALL_TIMEOUT the transaction is aborted: outputs to that master drop to 0, remaining beats are discarded, stall_abort[N] is set sticky until reset, and the FSM returns to IDLE with the pointer moved to the other master.
- Not defined: a stalled master holds the RAM indefinitely; stall_abort is tied 0.

Decomposition:
- Package axi_mem_pkg holds:
  - width constants ADDR_W=32, DATA_W=32, ID_W=4, LEN_W=8;
  - resp codes OKAY/SLVERR/DECERR;
  - burst-type enum;
  - FSM state enum.
- One natural sub-module: bram_sp, a single-port byte-enable synchronous RAM with 1-cycle read latency.

Test Plan:
- s0 single write 0x4000_0004 data 0xCAFE_0001, then read -> bresp OKAY, rdata 0xCAFE_0001, rlast on beat 1.
- s0 INCR awlen=3 at 0x4000_0010, then read back -> four words match, rlast only on 4th beat.
- s1 awlen=255 at 0x4000_1000 with wlast never asserted -> exactly 256 beats accepted, bresp SLVERR; pending s0 write granted next and completes.
- Both masters request each cycle -> grants alternate s0,s1,s0,s1…; no s0 transaction waits more than 260 cycles.
- s1 read awlen=255 with rready=0 forever:
  - with AXI_STALL_GUARD_EN -> abort after 1024 cycles, stall_abort=2'b10, s0 write completes;
  - without the macro -> s0 gets no awready for 20 µs.
- Write to 0x5000_0000 -> bresp DECERR, RAM unchanged; reset asserted mid-burst -> all valids 0 at once.
